program_loader: RTL

- Upstream companion to cpu_top: fills its byte-wide program memory from a byte stream and holds the CPU in reset until the image is complete.
- First pre-fills a region with NOP instruction pairs. Then writes streamed bytes from address 0 upward, and finally releases cpu_reset.
- Replaces file-based memory preload in both synthesis and simulation flows.

---
 rtl/isa_pkg.sv | 6 +
 rtl/loader_pkg.sv | 19 +
 rtl/program_loader.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Instruction-set constants shared with cpu_top; the loader only needs NOP.
package isa_pkg;

    localparam logic [3:0] NOP = 4'hE;

endpackage

// File: rtl/loader_pkg.sv
// State encoding and fill-pattern helpers for program_loader.
package loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FILL  = 3'd1;
    localparam state_t ST_LOAD  = 3'd2;
    localparam state_t ST_DONE  = 3'd3;
    localparam state_t ST_ERROR = 3'd4;

    // High byte of a NOP instruction pair; the odd byte of the pair is zero.
    localparam logic [7:0] NOP_PAIR = {isa_pkg::NOP, 4'b0000};

    function automatic logic [7:0] fill_byte(input logic odd_addr);
        return odd_addr ? 8'h00 : NOP_PAIR;
    endfunction

endpackage

// File: rtl/program_loader.sv
// Fills cpu_top program memory with NOP pairs, then with a streamed image,
// holding cpu_reset high until the whole image has been written.
//
// state | meaning
// IDLE  | after reset, waiting for start, cpu held in reset
// FILL  | writing NOP pairs to 0..FILL_BYTES-1, one per cycle
// LOAD  | accepting stream bytes, writing them from address 0 up
// DONE  | image complete, cpu_reset released one cycle after last write
// ERROR | image overflowed memory, cpu held in reset, stream ignored
module program_loader #(
    parameter int ADDR_BITS  = 8,
    parameter int DATA_BITS  = 8,
    parameter int MEM_BYTES  = 256,
    parameter int FILL_BYTES = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    output logic                 cpu_reset,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [ADDR_BITS:0]   bytes_loaded
);
    import loader_pkg::*;

    localparam int PW = ADDR_BITS + 1;
    localparam logic [PW-1:0] LAST_ADDR = PW'(MEM_BYTES - 1);
    localparam logic [PW-1:0] FILL_LAST = PW'((FILL_BYTES > 0) ? FILL_BYTES - 1 : 0);

    state_t               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        cnt_q, cnt_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic                 cpu_reset_q, cpu_reset_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 in_ready_q, in_ready_d;
    logic                 accept;
    logic [PW-1:0]        ptr_inc;

    assign accept  = in_ready_q && in_valid;
    assign ptr_inc = ptr_q + PW'(1);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        mem_we_d    = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_reset_d = cpu_reset_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        in_ready_d  = in_ready_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    cnt_d       = '0;
                    ptr_d       = '0;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    cpu_reset_d = 1'b1;
                    busy_d      = 1'b1;
                    if (FILL_BYTES > 0) begin
                        // The first fill write is issued together with the state change.
                        state_d  = ST_FILL;
                        mem_we_d = 1'b1;
                        addr_d   = '0;
                        wdata_d  = DATA_BITS'(fill_byte(1'b0));
                    end else begin
                        state_d    = ST_LOAD;
                        in_ready_d = 1'b1;
                    end
                end else if (state_q == ST_DONE) begin
                    cpu_reset_d = 1'b0;
                end
            end
            ST_FILL: begin
                if (ptr_q == FILL_LAST) begin
                    state_d    = ST_LOAD;
                    ptr_d      = '0;
                    in_ready_d = 1'b1;
                end else begin
                    ptr_d    = ptr_inc;
                    mem_we_d = 1'b1;
                    addr_d   = ptr_inc[ADDR_BITS-1:0];
                    wdata_d  = DATA_BITS'(fill_byte(ptr_inc[0]));
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    mem_we_d = 1'b1;
                    addr_d   = ptr_q[ADDR_BITS-1:0];
                    wdata_d  = in_data;
                    ptr_d    = ptr_inc;
                    cnt_d    = cnt_q + PW'(1);
                    if (in_last) begin
                        state_d    = ST_DONE;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else if (ptr_q == LAST_ADDR) begin
                        state_d    = ST_ERROR;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b0;
                        error_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cpu_reset_d = 1'b1;
                busy_d      = 1'b0;
                in_ready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign bytes_loaded = cnt_q;

endmodule
